rtc_bus_sequencer: RTL and testbench

- Parametrised, table-driven successor to the fixed RTC initialisation FSM.
- Executes a programmable list of RTC register accesses on the multiplexed address/data RTC bus (a_d, cs, rd, wr, all active-low). Each access is a write or a read.
- Bus phase lengths are set by parameters. Read data is returned with an index tag.
- Sits between the top-level control FSMs (init, time-set, time-read) and the RTC pad buffers. One block replaces the per-sequence hard-coded FSMs.

---
 rtl/rtc_bus_sequencer.sv | 274 +++++++++++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: table-driven sequencer for the multiplexed RTC bus
// (a_d, cs, rd, wr, all active-low). It runs a programmable list of
// register writes/reads and returns read data tagged with its table index.
// Optional abort support is built when RTC_SEQ_ABORT_EN is defined.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | strobes released, waiting for start
// S_ADDR | address phase: cs=0, wr=0, a_d=0, address driven
// S_GAP1 | strobes released between address and data phases
// S_DATA | data phase: write drives data with wr=0, read pulls rd=0
// S_GAP2 | strobes released after data; read result published here
module rtc_bus_sequencer #(
   parameter int DW     = 8,
   parameter int IW     = 4,
   parameter int T_ADDR = 4,
   parameter int T_GAP  = 2,
   parameter int T_DATA = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cfg_we,
   input  logic [IW-1:0] cfg_idx,
   input  logic          cfg_rnw,
   input  logic [DW-1:0] cfg_addr,
   input  logic [DW-1:0] cfg_data,
   input  logic          start,
   input  logic [IW:0]   count,
   input  logic          abort,
   input  logic [DW-1:0] ad_in,
   output logic [DW-1:0] ad_out,
   output logic          ad_oe,
   output logic          a_d,
   output logic          cs,
   output logic          rd,
   output logic          wr,
   output logic          busy,
   output logic          done,
   output logic          aborted,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic [IW-1:0] rd_idx
);

   localparam int         DEPTH   = 1 << IW;
   localparam logic [IW:0] CNT_MAX = (IW+1)'(DEPTH);
   localparam logic [3:0] LD_ADDR = 4'(T_ADDR - 1);
   localparam logic [3:0] LD_GAP  = 4'(T_GAP - 1);
   localparam logic [3:0] LD_DATA = 4'(T_DATA - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_GAP1 = 3'd2,
      S_DATA = 3'd3,
      S_GAP2 = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    tmr_q, tmr_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW:0]   run_len_q, run_len_d;
   logic [IW:0]   ptr_inc;

   logic [DW-1:0] ad_out_q, ad_out_d;
   logic          ad_oe_q, ad_oe_d;
   logic          a_d_q, a_d_d;
   logic          cs_q, cs_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          aborted_q, aborted_d;
   logic          rd_valid_q, rd_valid_d;
   logic [DW-1:0] rd_data_q, rd_data_d;
   logic [IW-1:0] rd_idx_q, rd_idx_d;

   logic          tbl_rnw_q  [DEPTH];
   logic [DW-1:0] tbl_addr_q [DEPTH];
   logic [DW-1:0] tbl_data_q [DEPTH];

   logic          abort_hit;

`ifdef RTC_SEQ_ABORT_EN
   logic abort_q, abort_d;

   // an abort request counts from the cycle it arrives; cleared once idle
   assign abort_hit = abort_q | abort;
   assign abort_d   = (state_q == S_IDLE) ? 1'b0 : abort_hit;

   // abort latch, only armed while a sequence is running
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) abort_q <= 1'b0;
      else        abort_q <= abort_d;
   end
`else
   logic unused_abort;

   assign unused_abort = abort;
   assign abort_hit    = 1'b0;
`endif

   assign ptr_inc = {1'b0, ptr_q} + {{IW{1'b0}}, 1'b1};

   // access table; contents survive reset and are frozen while running
   always_ff @(posedge clk) begin
      if (cfg_we && !busy_q) begin
         tbl_rnw_q[cfg_idx]  <= cfg_rnw;
         tbl_addr_q[cfg_idx] <= cfg_addr;
         tbl_data_q[cfg_idx] <= cfg_data;
      end
   end

   // next state, phase timer, pointer, then bus outputs decoded from next state
   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      ptr_d      = ptr_q;
      run_len_d  = run_len_q;
      done_d     = 1'b0;
      aborted_d  = 1'b0;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      rd_idx_d   = rd_idx_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (count == '0) begin
                  done_d = 1'b1;
               end else begin
                  run_len_d = (count > CNT_MAX) ? CNT_MAX : count;
                  ptr_d     = '0;
                  tmr_d     = LD_ADDR;
                  state_d   = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            if (tmr_q == '0) begin
               tmr_d   = LD_GAP;
               state_d = S_GAP1;
            end else begin
               tmr_d = tmr_q - 4'd1;
            end
         end
         S_GAP1: begin
            if (tmr_q == '0) begin
               tmr_d   = LD_DATA;
               state_d = S_DATA;
            end else begin
               tmr_d = tmr_q - 4'd1;
            end
         end
         S_DATA: begin
            if (tmr_q == '0) begin
               tmr_d   = LD_GAP;
               state_d = S_GAP2;
               // pads are sampled while rd is still low on the final data cycle
               if (tbl_rnw_q[ptr_q]) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = ad_in;
                  rd_idx_d   = ptr_q;
               end
            end else begin
               tmr_d = tmr_q - 4'd1;
            end
         end
         S_GAP2: begin
            if (tmr_q == '0) begin
               if (!abort_hit && (ptr_inc < run_len_q)) begin
                  ptr_d   = ptr_inc[IW-1:0];
                  tmr_d   = LD_ADDR;
                  state_d = S_ADDR;
               end else begin
                  ptr_d     = '0;
                  tmr_d     = '0;
                  state_d   = S_IDLE;
                  done_d    = 1'b1;
                  aborted_d = abort_hit;
               end
            end else begin
               tmr_d = tmr_q - 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ad_out_d = '0;
      ad_oe_d  = 1'b0;
      a_d_d    = 1'b1;
      cs_d     = 1'b1;
      rd_d     = 1'b1;
      wr_d     = 1'b1;
      busy_d   = (state_d != S_IDLE);

      case (state_d)
         S_ADDR: begin
            cs_d     = 1'b0;
            wr_d     = 1'b0;
            a_d_d    = 1'b0;
            ad_oe_d  = 1'b1;
            ad_out_d = tbl_addr_q[ptr_d];
         end
         S_DATA: begin
            cs_d = 1'b0;
            if (tbl_rnw_q[ptr_d]) begin
               rd_d = 1'b0;
            end else begin
               wr_d     = 1'b0;
               ad_oe_d  = 1'b1;
               ad_out_d = tbl_data_q[ptr_d];
            end
         end
         default: begin
         end
      endcase
   end

   // state and registered outputs; reset releases every strobe at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         tmr_q      <= '0;
         ptr_q      <= '0;
         run_len_q  <= '0;
         ad_out_q   <= '0;
         ad_oe_q    <= 1'b0;
         a_d_q      <= 1'b1;
         cs_q       <= 1'b1;
         rd_q       <= 1'b1;
         wr_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_idx_q   <= '0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         ptr_q      <= ptr_d;
         run_len_q  <= run_len_d;
         ad_out_q   <= ad_out_d;
         ad_oe_q    <= ad_oe_d;
         a_d_q      <= a_d_d;
         cs_q       <= cs_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         aborted_q  <= aborted_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_idx_q   <= rd_idx_d;
      end
   end

   assign ad_out   = ad_out_q;
   assign ad_oe    = ad_oe_q;
   assign a_d      = a_d_q;
   assign cs       = cs_q;
   assign rd       = rd_q;
   assign wr       = wr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign aborted  = aborted_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign rd_idx   = rd_idx_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Testbench for rtc_bus_sequencer: scoreboard of expected bus accesses,
// read results and completion pulses, checked by an independent monitor.
module tb_rtc_bus_sequencer;

   localparam int TA = 4;
   localparam int TG = 2;
   localparam int TD = 4;
   localparam int TE = TA + 2*TG + TD;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_we;
   logic [3:0] cfg_idx;
   logic       cfg_rnw;
   logic [7:0] cfg_addr;
   logic [7:0] cfg_data;
   logic       start;
   logic [4:0] count;
   logic       abort;
   logic [7:0] ad_in;
   logic [7:0] ad_out;
   logic       ad_oe, a_d, cs, rd, wr;
   logic       busy, done, aborted, rd_valid;
   logic [7:0] rd_data;
   logic [3:0] rd_idx;

   rtc_bus_sequencer #(.DW(8), .IW(4), .T_ADDR(TA), .T_GAP(TG), .T_DATA(TD)) dut (
      .clk(clk), .reset(reset),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_rnw(cfg_rnw),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .start(start), .count(count), .abort(abort),
      .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .a_d(a_d),
      .cs(cs), .rd(rd), .wr(wr),
      .busy(busy), .done(done), .aborted(aborted),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_idx(rd_idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic rnw; logic [7:0] addr; logic [7:0] data;} acc_t;
   typedef struct packed {logic [7:0] data; logic [3:0] idx;} rdx_t;
   typedef struct packed {logic [31:0] lat; logic [31:0] bsy; logic ab;} dn_t;

   acc_t exp_bus_q[$];
   rdx_t exp_rd_q[$];
   dn_t  exp_done_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;

   logic       m_rnw  [16];
   logic [7:0] m_addr [16];
   logic [7:0] m_data [16];
   logic [7:0] pad_val;

   // RTC pad model: returns pad_val only while the chip is being read
   assign ad_in = (!cs && !rd) ? pad_val : 8'hA5;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   int   ph = 0;
   int   acnt = 0, dcnt = 0, bcnt = 0;
   logic mon_rnw, mon_ok;
   logic [7:0] mon_addr, mon_data;
   acc_t e;
   rdx_t r;
   dn_t  d;

   // monitor: reconstructs bus accesses and pops expectations on each output event
   always @(negedge clk) begin
      if (!reset) begin
         ph   = 0;
         bcnt = 0;
      end else begin
         if (busy) bcnt++;
         if (!rd) begin
            check("oe_during_rd", ad_oe, 0);
            check("wr_during_rd", wr, 1);
         end
         if (rd_valid) begin
            check("rd_q_nonempty", exp_rd_q.size() != 0, 1);
            if (exp_rd_q.size() != 0) begin
               r = exp_rd_q.pop_front();
               check("rd_data", rd_data, r.data);
               check("rd_idx", rd_idx, r.idx);
               check("rd_valid_first_gap2", ph, 2);
            end
         end
         if (done) begin
            check("done_q_nonempty", exp_done_q.size() != 0, 1);
            if (exp_done_q.size() != 0) begin
               d = exp_done_q.pop_front();
               check("done_latency", cyc - start_cyc, d.lat);
               check("busy_cycles", bcnt, d.bsy);
               check("aborted", aborted, d.ab);
               check("busy_at_done", busy, 0);
            end
            bcnt = 0;
         end
         if (!cs && !a_d) begin
            if (ph != 1) begin
               ph = 1; acnt = 0; mon_addr = ad_out; mon_ok = 1'b1;
            end
            acnt++;
            if (ad_out != mon_addr || wr || !rd || !ad_oe) mon_ok = 1'b0;
         end else if (!cs && a_d) begin
            if (ph != 2) begin
               ph = 2; dcnt = 0; mon_rnw = !rd; mon_data = ad_out;
            end
            dcnt++;
            if (mon_rnw) begin
               if (rd || !wr || ad_oe) mon_ok = 1'b0;
            end else begin
               if (!rd || wr || !ad_oe || ad_out != mon_data) mon_ok = 1'b0;
            end
         end else if (ph == 2) begin
            check("acc_q_nonempty", exp_bus_q.size() != 0, 1);
            if (exp_bus_q.size() != 0) begin
               e = exp_bus_q.pop_front();
               check("bus_addr", mon_addr, e.addr);
               check("bus_rnw", mon_rnw, e.rnw);
               if (!e.rnw) check("bus_wdata", mon_data, e.data);
               check("addr_cycles", acnt, TA);
               check("data_cycles", dcnt, TD);
               check("phase_strobes", mon_ok, 1);
            end
            ph = 0;
         end
      end
   end

   task automatic cfg_wr(input int idx, input logic rnw, input logic [7:0] a, input logic [7:0] dt);
      @(negedge clk);
      cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_rnw = rnw; cfg_addr = a; cfg_data = dt;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      m_rnw[idx] = rnw; m_addr[idx] = a; m_data[idx] = dt;
   endtask

   task automatic push_acc(input int i);
      exp_bus_q.push_back({m_rnw[i], m_addr[i], m_data[i]});
      if (m_rnw[i]) exp_rd_q.push_back({pad_val, 4'(i)});
   endtask

   task automatic push_run(input int issued, input logic ab);
      for (int i = 0; i < issued; i++) push_acc(i);
      exp_done_q.push_back({32'(TE*issued), 32'(TE*issued), ab});
   endtask

   task automatic go(input logic [4:0] n);
      @(negedge clk);
      count = n; start = 1'b1;
      @(posedge clk); #1;
      start_cyc = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < max);
      check("done_seen", done, 1);
   endtask

   task automatic check_reset_outputs();
      check("rst_strobes", {cs, rd, wr, a_d}, 4'hF);
      check("rst_drive", {ad_oe, ad_out}, 0);
      check("rst_status", {busy, done, aborted, rd_valid}, 0);
      check("rst_rdout", {rd_data, rd_idx}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_rnw = 1'b0;
      cfg_addr = '0; cfg_data = '0; start = 1'b0; count = '0; abort = 1'b0;
      pad_val = 8'h00;
      #3 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs();
      @(negedge clk) reset = 1'b1;

      // three writes
      cfg_wr(0, 1'b0, 8'h21, 8'h00);
      cfg_wr(1, 1'b0, 8'h22, 8'h59);
      cfg_wr(2, 1'b0, 8'h23, 8'h12);
      push_run(3, 1'b0);
      go(5'd3);
      wait_done(60);

      // write followed by read
      cfg_wr(1, 1'b1, 8'h24, 8'h00);
      pad_val = 8'h47;
      push_run(2, 1'b0);
      go(5'd2);
      wait_done(60);

      // empty sequence
      push_run(0, 1'b0);
      go(5'd0);
      wait_done(5);

      // start and table write while busy are both ignored
      pad_val = 8'h3C;
      push_run(2, 1'b0);
      go(5'd2);
      repeat (5) @(posedge clk);
      #1;
      start = 1'b1; count = 5'd5;
      cfg_we = 1'b1; cfg_idx = 4'd1; cfg_rnw = 1'b0; cfg_addr = 8'h30; cfg_data = 8'h99;
      @(posedge clk); #1;
      start = 1'b0; cfg_we = 1'b0;
      wait_done(60);
      pad_val = 8'h6B;
      push_run(2, 1'b0);
      go(5'd2);
      wait_done(60);

      // full table, then clamped count, then pointer restarts at 0
      for (int i = 0; i < 15; i++) cfg_wr(i, 1'b0, 8'(8'h40 + i), 8'(8'h80 + i));
      cfg_wr(15, 1'b1, 8'h4F, 8'hFF);
      pad_val = 8'h5A;
      push_run(16, 1'b0);
      go(5'd16);
      wait_done(250);
      push_run(16, 1'b0);
      go(5'd20);
      wait_done(250);
      push_run(1, 1'b0);
      go(5'd1);
      wait_done(30);

      // abort in idle has no effect
      @(negedge clk) abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      push_run(1, 1'b0);
      go(5'd1);
      wait_done(30);

      // abort during the data phase of entry 1 of 5
`ifdef RTC_SEQ_ABORT_EN
      push_run(2, 1'b1);
`else
      push_run(5, 1'b0);
`endif
      go(5'd5);
      repeat (19) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      wait_done(100);

      // reset during the address phase of entry 2
      push_acc(0);
      push_acc(1);
      go(5'd3);
      repeat (26) @(posedge clk);
      #2 reset = 1'b0;
      #1 check_reset_outputs();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      push_run(1, 1'b0);
      go(5'd1);
      wait_done(30);

      repeat (3) @(negedge clk);
      check("bus_q_empty", exp_bus_q.size(), 0);
      check("rd_q_empty", exp_rd_q.size(), 0);
      check("done_q_empty", exp_done_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
